// File: rtl/utopia_phy_rx_source.sv
// Purpose: PHY-side UTOPIA L1 receive cell source; holds one cell and serializes it onto data/soc.
// Latency: clav rises 1 cycle after accept; first octet 1 cycle after en sampled low while loaded.
// Backpressure: cell_ready low while a cell is held; octet transfer pauses whenever en is high.
module utopia_phy_rx_source #(
    parameter int IfWidth   = 8,
    parameter int CellBytes = 53,
    parameter int CntWidth  = 16
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [CellBytes*8-1:0] cell_in,
    input  logic                   cell_valid,
    output logic                   cell_ready,
    input  logic                   en,
    output logic [IfWidth-1:0]     data,
    output logic                   soc,
    output logic                   valid,
    output logic                   clav,
    output logic [CntWidth-1:0]    cell_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SEND   = 2'd2
    } state_t;

    localparam logic [5:0] LastIdx = 6'(CellBytes - 1);

    state_t                 state, state_nxt;
    logic [CellBytes*8-1:0] cell_buf, cell_buf_nxt;
    logic [5:0]             idx, idx_nxt;
    logic [IfWidth-1:0]     data_nxt;
    logic                   soc_nxt, valid_nxt, clav_nxt;
    logic [CntWidth-1:0]    cell_count_nxt;
    logic [IfWidth-1:0]     cur_octet;

    // Octet idx of the held cell; octet 0 sits in the most significant byte.
    assign cur_octet = cell_buf[(CellBytes - 1 - int'(idx)) * IfWidth +: IfWidth];

    // A new cell can only be taken while nothing is held.
    assign cell_ready = (state == IDLE);

    // Next-state and next-output decode; everything holds unless a transfer happens.
    always_comb begin
        state_nxt      = state;
        cell_buf_nxt   = cell_buf;
        idx_nxt        = idx;
        data_nxt       = data;
        soc_nxt        = soc;
        valid_nxt      = 1'b0;
        clav_nxt       = clav;
        cell_count_nxt = cell_count;
        unique case (state)
            IDLE: begin
                if (cell_valid) begin
                    cell_buf_nxt = cell_in;
                    idx_nxt      = 6'd0;
                    clav_nxt     = 1'b1;
                    state_nxt    = LOADED;
                end
            end
            LOADED: begin
                if (!en) begin
                    data_nxt  = cur_octet;
                    soc_nxt   = 1'b1;
                    valid_nxt = 1'b1;
                    idx_nxt   = 6'd1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                soc_nxt = 1'b0;
                if (!en) begin
                    data_nxt  = cur_octet;
                    valid_nxt = 1'b1;
                    idx_nxt   = idx + 6'd1;
                    if (idx == LastIdx) begin
                        clav_nxt       = 1'b0;
                        cell_count_nxt = cell_count + CntWidth'(1);
                        state_nxt      = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, cell buffer and registered outputs; reset discards any cell in flight.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cell_buf   <= '0;
            idx        <= 6'd0;
            data       <= '0;
            soc        <= 1'b0;
            valid      <= 1'b0;
            clav       <= 1'b0;
            cell_count <= '0;
        end else begin
            state      <= state_nxt;
            cell_buf   <= cell_buf_nxt;
            idx        <= idx_nxt;
            data       <= data_nxt;
            soc        <= soc_nxt;
            valid      <= valid_nxt;
            clav       <= clav_nxt;
            cell_count <= cell_count_nxt;
        end
    end

endmodule

// File: tb/tb_utopia_phy_rx_source.sv
module tb_utopia_phy_rx_source;

    localparam int CB = 53;
    localparam int CW = 4;

    logic            clk_in = 1'b0;
    logic            reset  = 1'b1;
    logic [CB*8-1:0] cell_in = '0;
    logic            cell_valid = 1'b0;
    logic            cell_ready;
    logic            en = 1'b1;
    logic [7:0]      data;
    logic            soc, valid, clav;
    logic [CW-1:0]   cell_count;

    utopia_phy_rx_source #(.IfWidth(8), .CellBytes(CB), .CntWidth(CW)) dut (
        .clk_in(clk_in), .reset(reset), .cell_in(cell_in), .cell_valid(cell_valid),
        .cell_ready(cell_ready), .en(en), .data(data), .soc(soc), .valid(valid),
        .clav(clav), .cell_count(cell_count)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a held cell plus how many of its octets have gone out.
    logic [7:0]      mb [CB];
    bit              m_busy = 0;
    int              m_sent = 0;
    int              m_cnt  = 0;
    logic [7:0]      m_data = 8'h00;
    bit              m_valid = 0;
    bit              m_soc   = 0;
    logic [CB*8-1:0] pq [$];
    int              cyc_n = 0;
    int              last_end = -1;
    int              pulses = 0;
    int              pause_n = 0;

    function automatic logic [CB*8-1:0] mk_cell(input int mode, input logic [7:0] base);
        logic [CB*8-1:0] c;
        for (int k = 0; k < CB; k++) begin
            logic [7:0] b;
            case (mode)
                0: b = base + 8'(k);
                1: b = base;
                default: b = 8'($urandom);
            endcase
            c[CB*8-1-8*k -: 8] = b;
        end
        return c;
    endfunction

    // mode 0: en low; mode 1: random en and bursty producer; mode 2: 3-cycle pause after octet 9.
    task automatic step(input int mode);
        logic            v, e, acc, fin;
        logic [CB*8-1:0] c;
        for (int k = 0; k < CB; k++) c[k*8 +: 8] = 8'($urandom);
        v = 1'b0;
        if (pq.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
            v = 1'b1;
            c = pq[0];
        end
        e = 1'b0;
        if (mode == 1) e = ($urandom_range(0, 9) < 3);
        if (mode == 2 && m_busy && m_sent == 10 && pause_n < 3) begin
            e = 1'b1;
            pause_n++;
        end
        cell_valid = v;
        cell_in    = c;
        en         = e;
        chk("cell_ready", 32'(cell_ready), 32'(!m_busy));
        @(posedge clk_in);
        cyc_n++;
        acc = 1'b0;
        fin = 1'b0;
        m_valid = 0;
        m_soc   = 0;
        if (!m_busy) begin
            if (v) begin
                for (int k = 0; k < CB; k++) mb[k] = c[CB*8-1-8*k -: 8];
                m_busy = 1;
                m_sent = 0;
                acc = 1'b1;
            end
        end else if (!e) begin
            m_valid = 1;
            m_soc   = (m_sent == 0);
            m_data  = mb[m_sent];
            m_sent++;
            if (m_sent == CB) begin
                m_busy = 0;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                fin = 1'b1;
            end
        end
        if (acc) void'(pq.pop_front());
        #1;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("data", 32'(data), 32'(m_data));
        chk("soc", 32'(soc), 32'(m_soc));
        chk("clav", 32'(clav), 32'(m_busy));
        chk("cell_count", 32'(cell_count), 32'(m_cnt));
        if (valid && soc && last_end >= 0)
            chk("soc_gap_ge2", 32'((cyc_n - last_end) >= 2), 32'd1);
        if (valid) pulses++;
        if (fin) begin
            chk("pulses_per_cell", 32'(pulses), 32'(CB));
            pulses   = 0;
            last_end = cyc_n;
        end
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) step(mode);
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic do_reset();
        reset = 1'b0;
        cell_valid = 1'b0;
        en = 1'b1;
        #1;
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_soc", 32'(soc), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_clav", 32'(clav), 32'd0);
        chk("rst_count", 32'(cell_count), 32'd0);
        chk("rst_ready", 32'(cell_ready), 32'd1);
        m_busy = 0; m_sent = 0; m_cnt = 0; m_data = 8'h00;
        pulses = 0; last_end = -1;
        pq.delete();
        @(posedge clk_in);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int guard;
        #2;
        do_reset();

        // Single cell 0x00..0x34 with en held low.
        pq.push_back(mk_cell(0, 8'h00));
        run(58, 0);
        chk("single_count", 32'(cell_count), 32'd1);

        // Pause of three cycles after octet 0x09.
        pause_n = 0;
        pq.push_back(mk_cell(0, 8'h00));
        run(62, 2);
        chk("pause_applied", 32'(pause_n), 32'd3);
        chk("pause_count", 32'(cell_count), 32'd2);

        // Back-to-back cells A and B with the producer holding valid.
        pq.push_back(mk_cell(1, 8'hAA));
        pq.push_back(mk_cell(1, 8'hBB));
        run(115, 0);
        chk("b2b_count", 32'(cell_count), 32'd4);

        // en low with nothing loaded.
        run(10, 0);

        // Reset mid-cell after octet 20, then a fresh cell 0x10..0x44.
        pq.push_back(mk_cell(0, 8'h10));
        guard = 0;
        while (!(m_busy && m_sent == 21) && guard < 200) begin
            step(0);
            guard++;
        end
        chk("midcell_reached", 32'(guard < 200), 32'd1);
        do_reset();
        pq.push_back(mk_cell(0, 8'h10));
        run(58, 0);
        chk("post_reset_count", 32'(cell_count), 32'd1);

        // Random cells and random enable; count wraps past 2^CW.
        for (int i = 0; i < 20; i++) pq.push_back(mk_cell(2, 8'h00));
        guard = 0;
        while ((pq.size() > 0 || m_busy) && guard < 6000) begin
            step(1);
            guard++;
        end
        chk("random_done", 32'(guard < 6000), 32'd1);
        run(5, 1);
        chk("wrap_count", 32'(cell_count), 32'(21 % (1 << CW)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/utopia_phy_rx_source.md
Name: utopia_phy_rx_source

Overview:
- PHY-side cell source for the UTOPIA Level 1 receive port: the far end of the link that the ATM-layer receive core samples.
- Accepts one complete ATM cell at a time from a local producer (testbench or cell generator) through a valid/ready handshake.
- Advertises the cell with clav, then serializes it octet by octet onto data/soc under control of the ATM layer's active-low enable.
- Sits opposite the core receiver inside the Utopia receive path and drives the data, soc and clav signals that the receiver consumes.

Parameters:
- IfWidth, 8: data bus width in bits; only 8 is supported.
- CellBytes, 53: octets per cell (5 header + 48 payload).
- CntWidth, 16: width of the sent-cell counter.

Ports:
- clk_in  input  1  Utopia receive clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cell_in  input  CellBytes*8  packed cell; octet 0 (first header byte) in bits [CellBytes*8-1 -: 8], octet i in [CellBytes*8-1-8i -: 8].
- cell_valid  input  1  producer has a cell on cell_in.
- cell_ready  output  1  block can accept a cell this cycle.
- en  input  1  ATM-layer read enable, active low.
- data  output  IfWidth  cell octet.
- soc  output  1  start of cell; high with octet 0 only.
- valid  output  1  data/soc carry a freshly transferred octet this cycle.
- clav  output  1  cell available.
- cell_count  output  CntWidth  cells fully sent since reset, wraps.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE; data=0, soc=0, valid=0, clav=0, cell_count=0, octet index=0.
  - cell_ready=1, since it is decoded from IDLE.
  - Any cell in progress is discarded.
- Holding register: one cell buffer (CellBytes*8 flops) plus a 6-bit octet index.
- States:
  - IDLE:
    - cell_ready=1.
    - On an edge with cell_valid==1, capture cell_in, set index=0, go to LOADED, clav<=1.
    - en is ignored; valid<=0.
  - LOADED:
    - cell_ready=0, clav=1.
    - On an edge with en==0: data<=octet0, soc<=1, valid<=1, index<=1, go to SEND.
    - With en==1: valid<=0, data and soc hold.
  - SEND:
    - cell_ready=0.
    - On each edge with en==0: data<=octet[index], soc<=0, valid<=1, index<=index+1.
    - With en==1 (pause): valid<=0, data holds its last value, soc<=0, index holds.
    - On the edge that transfers octet CellBytes-1: clav<=0, cell_count<=cell_count+1 (modulo 2^CntWidth), go to IDLE.
- Latency:
  - First octet appears on data one cycle after the first edge where en is sampled low in LOADED.
  - The cell is advertised (clav=1) one cycle after acceptance.
  - Minimum gap between consecutive cells: one IDLE cycle for accept plus one LOADED cycle. So at least 2 edges separate the last octet of cell N from soc of cell N+1, even with en held low.
- Handshake: a transfer happens only on an edge with cell_valid && cell_ready. cell_in is ignored at all other times and need not stay stable after acceptance.
- Boundary cases:
  - en low in IDLE: no output activity.
  - cell_valid high in LOADED/SEND: not accepted; the producer holds until cell_ready.
  - cell_count wraps from all-ones to 0.
  - soc is never high on two consecutive valid octets.
  - Exactly CellBytes valid pulses occur per cell.
  - Reset asserted mid-cell aborts immediately with no partial-cell completion; after release the next accepted cell starts with soc.
- All outputs are registered except cell_ready (decoded from state).

Test Plan:
- Reset check: assert reset mid-simulation → data=0, soc=0, valid=0, clav=0, cell_count=0, cell_ready=1.
- Single cell, en held low: octet i = i (0x00..0x34) → clav=1 one cycle after accept; 53 consecutive valid cycles with data 0x00..0x34; soc only with 0x00; clav falls with 0x34; cell_count=1.
- Pause: en high for 3 cycles after octet 0x09 → valid=0 for 3 cycles, data stays 0x09, soc=0; resumes with 0x0A; total 53 valid pulses.
- Back-to-back: cell_valid held high with cells A (all 0xAA) and B (all 0xBB), en low → A is not overwritten during send; B accepted only in IDLE; B's soc arrives ≥2 edges after A's last octet; cell_count=2.
- Idle enable: en low for 10 cycles with no cell loaded → valid, soc and clav stay 0, data unchanged.
- Reset mid-cell: reset pulsed after octet 20 → all outputs zero; new cell of octets 0x10..0x44 then sends starting with 0x10 and soc=1; cell_count=1 after completion.
